// File: rtl/gcd_host_driver.sv
// Initiator for the GCD core's serial operand bus: request in, A/B load, wait, response out.
// Optional GCD_HOST_STATS_EN adds saturating job/timeout counters.
module gcd_host_driver #(
    parameter int WIDTH          = 16,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_gcd,
    output logic             rsp_err,
    output logic             gcd_start,
    output logic [WIDTH-1:0] gcd_data,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_result
`ifdef GCD_HOST_STATS_EN
    ,
    output logic [15:0]      stat_jobs,
    output logic [7:0]       stat_timeouts
`endif
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [WIDTH-1:0]  op_b, op_b_nxt;
    logic              req_ready_nxt, rsp_valid_nxt, rsp_err_nxt, gcd_start_nxt;
    logic [WIDTH-1:0]  rsp_gcd_nxt, gcd_data_nxt;

    // Every output is a register loaded with its next-cycle value computed here.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        op_b_nxt      = op_b;
        req_ready_nxt = 1'b0;
        rsp_valid_nxt = rsp_valid;
        rsp_gcd_nxt   = rsp_gcd;
        rsp_err_nxt   = rsp_err;
        gcd_start_nxt = gcd_start;
        gcd_data_nxt  = gcd_data;
        case (state)
            IDLE: begin
                req_ready_nxt = 1'b1;
                if (req_valid && req_ready) begin
                    req_ready_nxt = 1'b0;
                    op_b_nxt      = req_b;
                    if (req_a == '0 || req_b == '0) begin
                        // gcd(0,x)=x, gcd(0,0)=0: answer without the core
                        state_nxt     = RESP;
                        rsp_valid_nxt = 1'b1;
                        rsp_gcd_nxt   = req_a | req_b;
                        rsp_err_nxt   = 1'b0;
                    end else begin
                        state_nxt     = LOAD_A;
                        gcd_start_nxt = 1'b1;
                        gcd_data_nxt  = req_a;
                    end
                end
            end
            LOAD_A: begin
                state_nxt     = LOAD_B;
                gcd_start_nxt = 1'b1;
                gcd_data_nxt  = op_b;
            end
            LOAD_B: begin
                state_nxt = WAIT;
                cnt_nxt   = '0;
            end
            WAIT: begin
                cnt_nxt = cnt + 1'b1;
                if (gcd_done) begin
                    state_nxt     = RESP;
                    rsp_valid_nxt = 1'b1;
                    rsp_gcd_nxt   = gcd_result;
                    rsp_err_nxt   = 1'b0;
                    gcd_start_nxt = 1'b0;
                end else if (cnt_nxt == CW'(TIMEOUT_CYCLES)) begin
                    state_nxt     = RESP;
                    rsp_valid_nxt = 1'b1;
                    rsp_gcd_nxt   = '0;
                    rsp_err_nxt   = 1'b1;
                    gcd_start_nxt = 1'b0;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt     = IDLE;
                    rsp_valid_nxt = 1'b0;
                    req_ready_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            op_b      <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_gcd   <= '0;
            rsp_err   <= 1'b0;
            gcd_start <= 1'b0;
            gcd_data  <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            op_b      <= op_b_nxt;
            req_ready <= req_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_gcd   <= rsp_gcd_nxt;
            rsp_err   <= rsp_err_nxt;
            gcd_start <= gcd_start_nxt;
            gcd_data  <= gcd_data_nxt;
        end
    end

`ifdef GCD_HOST_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_jobs     <= '0;
            stat_timeouts <= '0;
        end else if (state == RESP && rsp_ready) begin
            if (stat_jobs != '1)
                stat_jobs <= stat_jobs + 1'b1;
            if (rsp_err && stat_timeouts != '1)
                stat_timeouts <= stat_timeouts + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gcd_host_driver.sv
// Scoreboard bench for gcd_host_driver with a behavioural serial GCD core model.
module tb_gcd_host_driver;
    localparam int W  = 16;
    localparam int TO = 20;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         req_valid = 1'b0, rsp_ready = 1'b1, gcd_done = 1'b0;
    logic [W-1:0] req_a = '0, req_b = '0, gcd_result = '0;
    logic         req_ready, rsp_valid, rsp_err, gcd_start;
    logic [W-1:0] rsp_gcd, gcd_data;
`ifdef GCD_HOST_STATS_EN
    logic [15:0]  stat_jobs;
    logic [7:0]   stat_timeouts;
`endif

    gcd_host_driver #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_gcd(rsp_gcd), .rsp_err(rsp_err),
        .gcd_start(gcd_start), .gcd_data(gcd_data), .gcd_done(gcd_done), .gcd_result(gcd_result)
`ifdef GCD_HOST_STATS_EN
        , .stat_jobs(stat_jobs), .stat_timeouts(stat_timeouts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [W-1:0] g; logic e; } rsp_t;
    rsp_t sb[$];
    int   checks = 0, errors = 0;
    int   start_cnt = 0;
    int   model_delay = 0;
    bit   model_hang = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] euclid(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a; y = b;
        while (y != 0) begin t = x % y; x = y; y = t; end
        return x;
    endfunction

    // Core model: latch A then B off the bus while start is high, raise done after a delay.
    int           ph = 0, cd = 0;
    logic [W-1:0] ma = '0, mb = '0;
    always @(negedge clk) begin
        if (!gcd_start) begin
            ph = 0; gcd_done = 1'b0;
        end else if (ph == 0) begin
            ma = gcd_data; ph = 1;
        end else if (ph == 1) begin
            mb = gcd_data; ph = 2; cd = model_delay;
        end else if (!model_hang) begin
            if (cd == 0) begin gcd_done = 1'b1; gcd_result = euclid(ma, mb); end
            else cd--;
        end
    end

    // Response monitor: every handshake must match the oldest expectation.
    rsp_t e;
    always @(negedge clk) begin
        if (gcd_start) start_cnt++;
        if (rsp_valid && rsp_ready) begin
            chk("rsp_expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rsp_gcd", 32'(rsp_gcd), 32'(e.g));
                chk("rsp_err", 32'(rsp_err), 32'(e.e));
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int i = 0; i < 100 && !req_ready; i++) tick();
        if (!req_ready) chk("req_ready_wait", 32'(req_ready), 1);
        req_a = a; req_b = b; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] g, input logic err);
        rsp_t r;
        r.g = g; r.e = err;
        sb.push_back(r);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 0);
        tick();
    endtask

    int s0;
    initial begin
        repeat (2) tick();
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_gcd",   32'(rsp_gcd), 0);
        chk("rst_rsp_err",   32'(rsp_err), 0);
        chk("rst_gcd_start", 32'(gcd_start), 0);
        chk("rst_gcd_data",  32'(gcd_data), 0);
        rst_n = 1'b1;
        tick();
        chk("idle_req_ready", 32'(req_ready), 1);

        // core path, bus sequencing
        push(16'd13, 1'b0);
        send(16'd143, 16'd78);
        chk("load_a_start", 32'(gcd_start), 1);
        chk("load_a_data",  32'(gcd_data), 143);
        tick();
        chk("load_b_start", 32'(gcd_start), 1);
        chk("load_b_data",  32'(gcd_data), 78);
        wait_drain();

        // zero-operand bypass
        s0 = start_cnt;
        push(16'd25, 1'b0);
        send(16'd0, 16'd25);
        chk("bypass_valid", 32'(rsp_valid), 1);
        chk("bypass_gcd",   32'(rsp_gcd), 25);
        wait_drain();
        push(16'd0, 1'b0);
        send(16'd0, 16'd0);
        wait_drain();
        chk("bypass_no_start", 32'(start_cnt), 32'(s0));

        // timeout after TO wait cycles
        model_hang = 1'b1;
        push(16'd0, 1'b1);
        send(16'd9, 16'd6);
        repeat (21) tick();
        chk("to_pre_valid", 32'(rsp_valid), 0);
        chk("to_pre_start", 32'(gcd_start), 1);
        tick();
        chk("to_valid", 32'(rsp_valid), 1);
        chk("to_start", 32'(gcd_start), 0);
        chk("to_err",   32'(rsp_err), 1);
        wait_drain();
        model_hang = 1'b0;

        // done on the same edge as the timeout: done wins
        model_delay = 19;
        push(16'd3, 1'b0);
        send(16'd9, 16'd6);
        wait_drain();
        model_delay = 2;

        // backpressure; a second request must not be taken
        rsp_ready = 1'b0;
        push(16'd6, 1'b0);
        send(16'd48, 16'd18);
        for (int i = 0; i < 100 && !rsp_valid; i++) tick();
        chk("bp_valid", 32'(rsp_valid), 1);
        req_a = 16'd1; req_b = 16'd1; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_gcd",       32'(rsp_gcd), 6);
            chk("bp_req_ready", 32'(req_ready), 0);
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_drain();
        push(16'd7, 1'b0);
        send(16'd35, 16'd21);
        wait_drain();

        // reset while waiting on the core aborts the job
        model_delay = 10;
        send(16'd9, 16'd6);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_req_ready", 32'(req_ready), 0);
        chk("mid_rst_valid",     32'(rsp_valid), 0);
        chk("mid_rst_gcd",       32'(rsp_gcd), 0);
        chk("mid_rst_err",       32'(rsp_err), 0);
        chk("mid_rst_start",     32'(gcd_start), 0);
        chk("mid_rst_data",      32'(gcd_data), 0);
        rst_n = 1'b1;
        model_delay = 0;
        push(16'd25, 1'b0);
        send(16'd100, 16'd75);
        wait_drain();
`ifdef GCD_HOST_STATS_EN
        chk("stat_jobs",     32'(stat_jobs), 1);
        chk("stat_timeouts", 32'(stat_timeouts), 0);
`endif

        repeat (30) tick();
        chk("sb_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gcd_host_driver.md
Name: gcd_host_driver

Overview:
- Initiator side of the GCD core's serial operand interface.
- Accepts an operand pair on a valid/ready request port and drives the core's start and shared data bus: operand A in one cycle, operand B in the next.
- Waits for the core's done, captures the result, and returns it on a valid/ready response port.
- Handles zero operands locally and bounds the core's runtime with a timeout.

Parameters:
- WIDTH, 16, operand/result width.
- TIMEOUT_CYCLES, 1023, maximum cycles spent in WAIT before the job is aborted with an error; must be >= 1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  request pair valid.
- req_ready  output  1  driver can accept a request.
- req_a  input  WIDTH  operand A.
- req_b  input  WIDTH  operand B.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts response.
- rsp_gcd  output  WIDTH  GCD result.
- rsp_err  output  1  1 = job aborted by timeout.
- gcd_start  output  1  start to GCD core.
- gcd_data  output  WIDTH  serial operand bus to GCD core.
- gcd_done  input  1  core done flag (level).
- gcd_result  input  WIDTH  core result register (A register output).

Behaviour:
- Reset (rst_n low at a clk edge) applies regardless of state:
  - State goes to IDLE.
  - Outputs: req_ready=0 during reset, rsp_valid=0, rsp_gcd=0, rsp_err=0, gcd_start=0, gcd_data=0.
  - Timeout counter and captured operands are cleared.
- All outputs are registered.
- States: IDLE, LOAD_A, LOAD_B, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - If req_valid is high at an edge, req_a/req_b are captured and req_ready drops the next cycle.
  - If captured A==0 or B==0: skip the core and go to RESP with rsp_gcd = A|B, which gives gcd(0,x)=x and gcd(0,0)=0. rsp_err=0. gcd_start stays 0.
  - Otherwise go to LOAD_A.
- LOAD_A: exactly one cycle with gcd_start=1, gcd_data=A. Next state is LOAD_B.
- LOAD_B: exactly one cycle with gcd_start=1, gcd_data=B. Next state is WAIT. The timeout counter is cleared here.
- WAIT:
  - gcd_start stays 1 and gcd_data holds B.
  - The counter increments each cycle.
  - If gcd_done is sampled high: rsp_gcd<=gcd_result, rsp_err<=0, go to RESP.
  - Else if the counter reaches TIMEOUT_CYCLES: rsp_gcd<=0, rsp_err<=1, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
  - gcd_done is ignored in every state except WAIT.
- RESP:
  - rsp_valid=1 and gcd_start=0.
  - rsp_gcd and rsp_err hold stable until rsp_ready is high at an edge, then return to IDLE with rsp_valid=0.
  - No new request is accepted while in RESP; req_ready=0.
- Latency, from the accept edge to rsp_valid high:
  - Zero-operand path: 1 cycle.
  - Core path: 3 + N cycles, where N is the WAIT cycles until done.
- Back-to-back operation: the minimum gap between accepts is one IDLE cycle after the response handshake.
- Reset mid-operation aborts the job:
  - No response is produced.
  - gcd_start deasserts on the reset edge, so the core sees start low.

Optional Feature:
- Macro: GCD_HOST_STATS_EN.
- Defined: adds outputs stat_jobs (16 bits) and stat_timeouts (8 bits).
  - stat_jobs increments on every response handshake.
  - stat_timeouts increments on every response handshake with rsp_err=1.
  - Both saturate at all-ones and are cleared by rst_n.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- A=143, B=78 with a behavioural core model:
  - gcd_data=143 in LOAD_A and 78 in LOAD_B, with gcd_start high in both.
  - Then rsp_valid=1, rsp_gcd=13, rsp_err=0.
- A=0, B=25:
  - rsp_valid high 1 cycle after accept with rsp_gcd=25.
  - gcd_start never asserted.
- A=0, B=0: rsp_gcd=0, rsp_err=0 via the bypass path.
- TIMEOUT_CYCLES=20, core model holds gcd_done=0, A=9, B=6:
  - RESP entered after 20 WAIT cycles with rsp_err=1, rsp_gcd=0.
  - gcd_start drops in RESP.
- Response backpressure: A=48, B=18, rsp_ready held low 5 cycles.
  - rsp_gcd=6 is stable throughout, req_ready=0, and a second req_valid is not accepted.
  - After rsp_ready=1 the driver returns to IDLE and accepts A=35, B=21, giving rsp_gcd=7.
- rst_n low for 1 cycle in WAIT:
  - All outputs return to reset values and no rsp_valid pulse occurs.
  - A subsequent A=100, B=75 gives rsp_gcd=25.
  - With GCD_HOST_STATS_EN defined: stat_jobs=1 and stat_timeouts=0 afterwards.
